// File: rtl/sha256_block_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | Package : sha256_seq_pkg                                                 |
// | Shared state encoding, block/message codes and helpers for the sequencer.|
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sha256_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam logic [1:0] HB_IV   = 2'd0;
  localparam logic [1:0] HB_ADD1 = 2'd1;
  localparam logic [1:0] HB_ADD2 = 2'd2;
  localparam logic [1:0] HB_ADD3 = 2'd3;

  localparam logic [1:0] MSG_HDR1   = 2'd0;
  localparam logic [1:0] MSG_HDR2   = 2'd1;
  localparam logic [1:0] MSG_DIGEST = 2'd2;

  localparam int SHA_ROUNDS_MAX = 64;

`ifdef SHA_DOUBLE_HASH_EN
  localparam int NBLK = 3;
`else
  localparam int NBLK = 2;
`endif
  localparam logic [1:0] BLK_LAST = 2'(NBLK - 1);

  function automatic logic [1:0] hb_code(input logic [1:0] blk);
    case (blk)
      2'd0:    hb_code = HB_ADD1;
      2'd1:    hb_code = HB_ADD2;
      default: hb_code = HB_ADD3;
    endcase
  endfunction

  // Only the second header block chains from the accumulators.
  function automatic logic starts_from_iv(input logic [1:0] msel);
    return (msel == MSG_HDR1) || (msel == MSG_DIGEST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_block_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | Interface : sha256_block_sequencer_if                                    |
// | Host request / core control signals of the SHA-256 block sequencer.      |
// | Rev       : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sha256_block_sequencer_if;
  logic       start;
  logic       abort;
  logic       ready;
  logic       busy;
  logic       load_msg;
  logic [1:0] msg_sel;
  logic       round_en;
  logic [5:0] round_idx;
  logic [1:0] hblock;
  logic       iv_sel;
  logic       done;

  modport master (
    output start, abort,
    input  ready, busy, load_msg, msg_sel, round_en, round_idx, hblock, iv_sel, done
  );

  modport slave (
    input  start, abort,
    output ready, busy, load_msg, msg_sel, round_en, round_idx, hblock, iv_sel, done
  );
endinterface

`default_nettype wire

// File: rtl/sha256_block_sequencer_round_counter.sv
// +--------------------------------------------------------------------------+
// | Module : sha256_round_counter                                            |
// | Round index counter with clear, enable and terminal-count output.        |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sha256_round_counter #(
  parameter int ROUNDS = 64
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_clear,
  input  wire logic       i_enable,
  output logic      [5:0] o_count,
  output logic            o_last
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  logic [5:0] count_q;
  logic [5:0] count_d;

  assign o_last  = i_enable && (count_q == LAST_IDX);
  assign o_count = count_q;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = 6'd0;
    end else if (i_enable) begin
      count_d = o_last ? 6'd0 : count_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 6'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_block_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module : sha256_block_sequencer                                          |
// | Sequences LOAD/ROUND/ACCUM passes over the header blocks of a SHA-256    |
// | hash; SHA_DOUBLE_HASH_EN adds a digest pass (Bitcoin double SHA-256).    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sha256_block_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int ROUNDS = SHA_ROUNDS_MAX
) (
  input wire logic                 clk,
  input wire logic                 rst,
  sha256_block_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;
  logic [1:0] blk_q, blk_d;
  logic [1:0] hblock_q, hblock_d;
  logic [1:0] msg_sel_q, msg_sel_d;
  logic       load_msg_q, load_msg_d;
  logic       round_en_q, round_en_d;
  logic       iv_sel_q, iv_sel_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [5:0] rnd_count;
  logic       rnd_last;

  sha256_round_counter #(.ROUNDS(ROUNDS)) u_round_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  ((state_q != ST_ROUND) || bus.abort),
    .i_enable (state_q == ST_ROUND),
    .o_count  (rnd_count),
    .o_last   (rnd_last)
  );

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    hblock_d = hblock_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_LOAD;
          blk_d   = 2'd0;
        end
      end
      ST_LOAD:  state_d = ST_ROUND;
      ST_ROUND: begin
        if (rnd_last) begin
          state_d  = ST_ACCUM;
          hblock_d = hb_code(blk_q);
        end
      end
      ST_ACCUM: begin
        if (blk_q < BLK_LAST) begin
          blk_d   = blk_q + 2'd1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d = ST_IDLE;
    end
    // Returning to IDLE by any path drops any partial accumulation.
    if (state_d == ST_IDLE) begin
      hblock_d = HB_IV;
      blk_d    = 2'd0;
    end

    load_msg_d = (state_d == ST_LOAD);
    round_en_d = (state_d == ST_ROUND);
    done_d     = (state_d == ST_DONE);
    ready_d    = (state_d == ST_IDLE);
    msg_sel_d  = blk_d;
    iv_sel_d   = starts_from_iv(blk_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blk_q      <= 2'd0;
      hblock_q   <= HB_IV;
      msg_sel_q  <= MSG_HDR1;
      load_msg_q <= 1'b0;
      round_en_q <= 1'b0;
      iv_sel_q   <= 1'b1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      hblock_q   <= hblock_d;
      msg_sel_q  <= msg_sel_d;
      load_msg_q <= load_msg_d;
      round_en_q <= round_en_d;
      iv_sel_q   <= iv_sel_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = !ready_q;
  assign bus.load_msg  = load_msg_q;
  assign bus.msg_sel   = msg_sel_q;
  assign bus.round_en  = round_en_q;
  assign bus.round_idx = round_en_q ? rnd_count : 6'd0;
  assign bus.hblock    = hblock_q;
  assign bus.iv_sel    = iv_sel_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module : tb_sha256_block_sequencer                                       |
// | Scoreboard bench for the SHA-256 block sequencer.                        |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sha256_block_sequencer;

  localparam int ROUNDS  = 64;
  localparam int BLK_CYC = ROUNDS + 2;
`ifdef SHA_DOUBLE_HASH_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [1:0] msel;
    logic       iv;
    logic [1:0] hb;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  int   n_done;
  int   ridx_exp;
  ev_t  exp_q[$];

  sha256_block_sequencer_if bus();

  sha256_block_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every load_msg/done pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t ev;
    if (bus.load_msg === 1'b1 || bus.done === 1'b1) begin
      if (bus.done === 1'b1) n_done++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d load_msg=%0b done=%0b, required no event",
                 cyc, bus.load_msg, bus.done);
      end else begin
        ev = exp_q.pop_front();
        if (cyc !== ev.cyc || bus.done !== ev.is_done) begin
          n_fail++;
          $display("FAIL event_timing: got cycle %0d done=%0b, required cycle %0d done=%0b",
                   cyc, bus.done, ev.cyc, ev.is_done);
        end
        n_cmp++;
        if (!ev.is_done) begin
          if (bus.msg_sel !== ev.msel || bus.iv_sel !== ev.iv) begin
            n_fail++;
            $display("FAIL load_fields: cycle %0d msg_sel=%0d iv_sel=%0b, required msg_sel=%0d iv_sel=%0b",
                     cyc, bus.msg_sel, bus.iv_sel, ev.msel, ev.iv);
          end
        end else if (bus.hblock !== ev.hb) begin
          n_fail++;
          $display("FAIL done_hblock: cycle %0d hblock=%0d, required %0d", cyc, bus.hblock, ev.hb);
        end
      end
    end
    if (bus.round_en === 1'b1) begin
      n_cmp++;
      if (int'(bus.round_idx) !== ridx_exp) begin
        n_fail++;
        $display("FAIL round_idx: cycle %0d round_idx=%0d, required %0d", cyc, bus.round_idx, ridx_exp);
      end
      ridx_exp++;
    end else begin
      ridx_exp = 0;
      if (!rst && bus.round_idx !== 6'd0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL round_idx_idle: cycle %0d round_idx=%0d, required 0", cyc, bus.round_idx);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic push_ev(input int c, input bit d, input int msel, input bit iv, input int hb);
    ev_t e;
    e.cyc = c; e.is_done = d; e.msel = 2'(msel); e.iv = iv; e.hb = 2'(hb);
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int t);
    for (int b = 0; b < NB; b++) push_ev(t + 1 + b * BLK_CYC, 1'b0, b, (b != 1), 0);
    push_ev(t + 1 + NB * BLK_CYC, 1'b1, 0, 1'b0, NB);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_cmp++;
    if ({bus.ready, bus.busy, bus.load_msg, bus.done, bus.round_en} !== 5'b10000 ||
        bus.hblock !== 2'd0 || bus.round_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_held: ready=%0b busy=%0b load=%0b done=%0b ren=%0b hblock=%0d ridx=%0d, required 1 0 0 0 0 0 0",
               bus.ready, bus.busy, bus.load_msg, bus.done, bus.round_en, bus.hblock, bus.round_idx);
    end
    rst = 1'b0;
    step(2);
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.hblock !== 2'd0 || bus.round_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_released: ready=%0b busy=%0b hblock=%0d ridx=%0d, required 1 0 0 0",
               bus.ready, bus.busy, bus.hblock, bus.round_idx);
    end
  endtask

  task automatic check_hb(input string name, input int c, input int exp);
    wait_until(c);
    n_cmp++;
    if (int'(bus.hblock) !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d hblock=%0d, required %0d", name, cyc, bus.hblock, exp);
    end
  endtask

  task automatic test_full_hash();
    int t, d;
    t = cyc;
    d = t + 1 + NB * BLK_CYC;
    bus.start = 1'b1;
    push_run(t);
    step(1);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: ready=%0b busy=%0b, required 0 1", bus.ready, bus.busy);
    end
    check_hb("hblock_before_accum1", t + 65, 0);
    check_hb("hblock_accum1", t + 66, 1);
    check_hb("hblock_hold1", t + 131, 1);
    check_hb("hblock_accum2", t + 132, 2);
`ifdef SHA_DOUBLE_HASH_EN
    check_hb("hblock_hold2", t + 197, 2);
    check_hb("hblock_accum3", t + 198, 3);
`endif
    wait_until(d + 1);
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.hblock !== 2'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_hash_end: ready=%0b hblock=%0d pending=%0d, required 1 0 0",
               bus.ready, bus.hblock, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int t;
    t = cyc;
    bus.start = 1'b1;
    push_ev(t + 1, 1'b0, 0, 1'b1, 0);
    step(1);
    bus.start = 1'b0;
    wait_until(t + 40);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.hblock !== 2'd0 || bus.round_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: cycle %0d ready=%0b busy=%0b hblock=%0d ren=%0b, required 1 0 0 0",
               cyc, bus.ready, bus.busy, bus.hblock, bus.round_en);
    end
    wait_until(t + 45);
    bus.start = 1'b1;
    push_run(t + 45);
    step(1);
    bus.start = 1'b0;
    wait_until(t + 45 + NB * BLK_CYC + 2);
    n_cmp++;
    if (bus.ready !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_restart: ready=%0b pending=%0d, required 1 0", bus.ready, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t, t2, done0;
    t     = cyc;
    t2    = t + NB * BLK_CYC + 2;
    done0 = n_done;
    bus.start = 1'b1;
    push_run(t);
    push_run(t2);
    wait_until(t2);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_between_runs: cycle %0d ready=%0b, required 1", cyc, bus.ready);
    end
    step(1);
    bus.start = 1'b0;
    wait_until(t2 + NB * BLK_CYC + 2);
    n_cmp++;
    if (n_done - done0 !== 2 || exp_q.size() != 0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start: dones=%0d pending=%0d ready=%0b, required 2 0 1",
               n_done - done0, exp_q.size(), bus.ready);
    end
  endtask

  task automatic test_rst_and_idle_abort();
    int t, done0;
    t     = cyc;
    done0 = n_done;
    bus.start = 1'b1;
    push_ev(t + 1, 1'b0, 0, 1'b1, 0);
    push_ev(t + 1 + BLK_CYC, 1'b0, 1, 1'b0, 0);
    check_hb("hblock_before_rst", t + 99, 1);
    wait_until(t + 100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.hblock !== 2'd0 || bus.round_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_midrun: cycle %0d ready=%0b busy=%0b hblock=%0d ren=%0b, required 1 0 0 0",
               cyc, bus.ready, bus.busy, bus.hblock, bus.round_en);
    end
    step(4);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.load_msg !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_idle: ready=%0b busy=%0b load=%0b, required 1 0 0",
               bus.ready, bus.busy, bus.load_msg);
    end
    step(3);
    n_cmp++;
    if (bus.ready !== 1'b1 || n_done != done0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stay_idle: ready=%0b new_dones=%0d pending=%0d, required 1 0 0",
               bus.ready, n_done - done0, exp_q.size());
    end
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_fail    = 0;
    n_done    = 0;
    ridx_exp  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_full_hash();
    test_abort();
    test_back_to_back();
    test_rst_and_idle_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
